cmos_axis_packer: RTL and testbench
===================================

// Module: cmos_axis_packer
// PURPOSE
//  Downstream of the OV5640 capture stage: takes its RGB888 pixel stream (vsync/href/de/ce/data) on cam_pclk
//  and repacks it as AXI4-Stream video (tuser=SOF, tlast=EOL) via a small synchronous FIFO for a VDMA/frame writer.
//  Frames hitting a full FIFO are truncated and dropped to next frame start, so downstream never sees a torn frame.
// PARAMETERS
//  FIFO_AW     4    FIFO address width; depth = 2**FIFO_AW entries of 26 bits {sof,eol,data[23:0]}
//  VSYNC_POL   1    active level of in_vsync (1 = high pulse marks frame boundary)
// PORTS
//  cam_pclk        in   1   pixel clock; all logic on rising edge
//  rst_n           in   1   reset, asynchronous, active-low
//  in_vsync        in   1   frame sync from capture stage
//  in_href         in   1   line valid from capture stage
//  in_de           in   1   data enable from capture stage
//  in_ce           in   1   clock enable; pixel accepted when in_ce & in_de
//  in_data         in   24  RGB888 {R,G,B}
//  m_axis_tdata    out  24  pixel data
//  m_axis_tvalid   out  1   FIFO non-empty
//  m_axis_tready   in   1   downstream ready
//  m_axis_tuser    out  1   first pixel of frame
//  m_axis_tlast    out  1   last pixel of line
//  ovf_sticky      out  1   set on any dropped frame; cleared only by reset
//  drop_cnt        out  16  frames dropped, saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset: all outputs 0; FIFO empty; state WAIT_SOF; hold register empty; sof_pend=0.
//  - vs_edge = in_vsync transitions to VSYNC_POL level (registered once, edge on 1-cycle-delayed copy).
//  - pix = in_ce & in_de. Last pixel of a line = held pixel when in_href samples 1->0 (registered copy).
//  - Hold register: each new pix loads hold; previous hold content pushed with eol=0. On href fall,
//    hold pushed with eol=1 and emptied. Push latency in->FIFO write: 1 cycle after the next pix/href fall.
//  - sof bit set on first pixel pushed after vs_edge (sof_pend set by vs_edge, cleared on that push).
//  - FSM: WAIT_SOF -> ACTIVE on vs_edge (pixels before first vs_edge discarded).
//         ACTIVE: push as above; push while FIFO full -> DROP, word lost, ovf_sticky=1, drop_cnt+1.
//         DROP: discard all pixels, hold emptied; vs_edge -> ACTIVE with sof_pend=1.
//  - vs_edge while hold non-empty (href never fell): hold pushed with eol=1 same cycle, then new frame.
//  - Simultaneous push and pop when full: pop frees slot, push succeeds (no drop).
//  - Simultaneous pix and href fall cannot occur (de==href upstream); if it does, pix wins, eol on next fall.
//  - FIFO: first-word-fall-through; tdata/tuser/tlast valid whenever tvalid; pop on tvalid & tready;
//    tvalid/tdata stable while tready=0. Pointers FIFO_AW+1 bits, full/empty by MSB compare, wrap naturally.
//  - Already-queued words of a dropped frame still drain; downstream discards until next tuser.
//  - rst_n assertion mid-frame: immediate clear, restart in WAIT_SOF.
// CONFIGURATION
//  CMOS_AXIS_STATS_EN defined: adds outputs line_len[11:0] (pixels in last complete line) and
//   frame_lines[11:0] (lines in last complete frame), updated on href fall / vs_edge, reset 0, saturate 4095.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1. Reset, then 2 frames of 4 lines x 8 pixels, tready=1 -> 64 beats, tuser on beats 0 and 32, tlast every 8th.
//  2. Pixels before first vs_edge (1 line x 8) -> no output, drop_cnt=0.
//  3. FIFO_AW=4, tready=0 for whole frame of 2x20 px -> 16 words queued, ovf_sticky=1, drop_cnt=1;
//     next frame with tready=1 -> tuser on first word after the 16 drained.
//  4. tready toggled 1/0 each cycle, 1 line x 8 px -> 8 beats in order, data held stable on tready=0 cycles.
//  5. vs_edge with href stuck high after 5 px -> 5th pixel emitted with tlast=1, next frame tuser=1.
//  6. rst_n pulsed low mid-line -> tvalid=0 next edge, drop_cnt=0; stats (if CMOS_AXIS_STATS_EN) = 8/4 after test 1.

Source files
------------

// File: rtl/cmos_axis_packer.sv
// Repacks the OV5640 capture stream (vsync/href/de/ce/data) into AXI4-Stream video through a small FWFT FIFO.
// Optional build macro CMOS_AXIS_STATS_EN adds the line_len / frame_lines measurement outputs.
module cmos_axis_packer #(
    parameter int FIFO_AW   = 4,
    parameter bit VSYNC_POL = 1'b1
) (
    input  logic        cam_pclk,
    input  logic        rst_n,
    input  logic        in_vsync,
    input  logic        in_href,
    input  logic        in_de,
    input  logic        in_ce,
    input  logic [23:0] in_data,
    output logic [23:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    output logic        ovf_sticky,
    output logic [15:0] drop_cnt
`ifdef CMOS_AXIS_STATS_EN
    ,
    output logic [11:0] line_len,
    output logic [11:0] frame_lines
`endif
);

    // state    | meaning
    // WAIT_SOF | idle after reset, pixels discarded until the first frame start
    // ACTIVE   | pixels of the current frame are packed into the FIFO
    // DROP     | frame hit a full FIFO; discard everything until the next frame start
    typedef enum logic [1:0] {WAIT_SOF, ACTIVE, DROP} state_t;

    localparam int DEPTH = 2 ** FIFO_AW;

    state_t             state_q, state_d;
    logic               vs_q, vs_dly_q, href_q;
    logic [23:0]        hold_q, hold_d;
    logic               hold_vld_q, hold_vld_d;
    logic               hold_sof_q, hold_sof_d;
    logic               sof_pend_q, sof_pend_d;
    logic               ovf_q;
    logic [15:0]        drop_cnt_q;
    logic [25:0]        mem [DEPTH];
    logic [FIFO_AW:0]   wp_q, rp_q;
    logic [25:0]        rd_word, push_word;
    logic               push, drop, wr_en, pop, fifo_full, fifo_empty;
    logic               pix, href_fall, vs_edge;

    assign pix       = in_ce & in_de;
    assign href_fall = href_q & ~in_href;
    assign vs_edge   = (vs_q == VSYNC_POL) && (vs_dly_q != VSYNC_POL);

    assign fifo_empty = (wp_q == rp_q);
    assign fifo_full  = (wp_q[FIFO_AW] != rp_q[FIFO_AW]) &&
                        (wp_q[FIFO_AW-1:0] == rp_q[FIFO_AW-1:0]);
    assign pop        = ~fifo_empty & m_axis_tready;
    assign wr_en      = push & ~drop;
    assign rd_word    = mem[rp_q[FIFO_AW-1:0]];

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        hold_sof_d = hold_sof_q;
        sof_pend_d = sof_pend_q;
        push       = 1'b0;
        push_word  = '0;
        drop       = 1'b0;
        case (state_q)
            WAIT_SOF: begin
                hold_vld_d = 1'b0;
                if (vs_edge) begin
                    state_d    = ACTIVE;
                    sof_pend_d = 1'b1;
                end
            end
            ACTIVE: begin
                if (vs_edge) begin
                    // line never closed by href: flush the held pixel as end of line
                    push       = hold_vld_q;
                    push_word  = {hold_sof_q, 1'b1, hold_q};
                    hold_vld_d = 1'b0;
                    sof_pend_d = 1'b1;
                end else if (pix) begin
                    push       = hold_vld_q;
                    push_word  = {hold_sof_q, 1'b0, hold_q};
                    hold_d     = in_data;
                    hold_vld_d = 1'b1;
                    hold_sof_d = sof_pend_q;
                    sof_pend_d = 1'b0;
                end else if (href_fall && hold_vld_q) begin
                    push       = 1'b1;
                    push_word  = {hold_sof_q, 1'b1, hold_q};
                    hold_vld_d = 1'b0;
                end
                if (push && fifo_full && !pop) begin
                    drop       = 1'b1;
                    hold_vld_d = 1'b0;
                    if (!vs_edge) state_d = DROP;
                end
            end
            DROP: begin
                hold_vld_d = 1'b0;
                if (vs_edge) begin
                    state_d    = ACTIVE;
                    sof_pend_d = 1'b1;
                end
            end
            default: state_d = WAIT_SOF;
        endcase
    end

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WAIT_SOF;
            vs_q       <= ~VSYNC_POL;
            vs_dly_q   <= ~VSYNC_POL;
            href_q     <= 1'b0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            hold_sof_q <= 1'b0;
            sof_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
            wp_q       <= '0;
            rp_q       <= '0;
        end else begin
            state_q    <= state_d;
            vs_q       <= in_vsync;
            vs_dly_q   <= vs_q;
            href_q     <= in_href;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            hold_sof_q <= hold_sof_d;
            sof_pend_q <= sof_pend_d;
            if (drop) begin
                ovf_q <= 1'b1;
                if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            if (wr_en) wp_q <= wp_q + 1'b1;
            if (pop)   rp_q <= rp_q + 1'b1;
        end
    end

    always_ff @(posedge cam_pclk) begin
        if (wr_en) mem[wp_q[FIFO_AW-1:0]] <= push_word;
    end

    // storage is not reset, so gate the read port to keep outputs at 0 while empty
    assign m_axis_tvalid = ~fifo_empty;
    assign m_axis_tdata  = fifo_empty ? 24'd0 : rd_word[23:0];
    assign m_axis_tlast  = ~fifo_empty & rd_word[24];
    assign m_axis_tuser  = ~fifo_empty & rd_word[25];
    assign ovf_sticky    = ovf_q;
    assign drop_cnt      = drop_cnt_q;

`ifdef CMOS_AXIS_STATS_EN
    logic [11:0] pix_cnt_q, line_cnt_q, line_len_q, frame_lines_q;

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
        end else if (vs_edge) begin
            if (state_q == ACTIVE) frame_lines_q <= line_cnt_q;
            line_cnt_q <= '0;
            pix_cnt_q  <= '0;
        end else if (state_q == ACTIVE) begin
            if (pix) begin
                if (pix_cnt_q != 12'hFFF) pix_cnt_q <= pix_cnt_q + 12'd1;
            end else if (href_fall) begin
                line_len_q <= pix_cnt_q;
                pix_cnt_q  <= '0;
                if (line_cnt_q != 12'hFFF) line_cnt_q <= line_cnt_q + 12'd1;
            end
        end
    end

    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
`endif

endmodule

// File: tb/tb_cmos_axis_packer.sv
// Scoreboard bench for cmos_axis_packer: expected beats are queued as pixels are driven and
// compared when the AXI-Stream side delivers them.
module tb_cmos_axis_packer;

    logic        cam_pclk = 1'b0;
    logic        rst_n;
    logic        in_vsync, in_href, in_de, in_ce;
    logic [23:0] in_data;
    logic [23:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tuser, m_axis_tlast;
    logic        ovf_sticky;
    logic [15:0] drop_cnt;
`ifdef CMOS_AXIS_STATS_EN
    logic [11:0] line_len, frame_lines;
`endif

    cmos_axis_packer #(.FIFO_AW(4), .VSYNC_POL(1'b1)) dut (
        .cam_pclk      (cam_pclk),
        .rst_n         (rst_n),
        .in_vsync      (in_vsync),
        .in_href       (in_href),
        .in_de         (in_de),
        .in_ce         (in_ce),
        .in_data       (in_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .ovf_sticky    (ovf_sticky),
        .drop_cnt      (drop_cnt)
`ifdef CMOS_AXIS_STATS_EN
        ,
        .line_len      (line_len),
        .frame_lines   (frame_lines)
`endif
    );

    always #5 cam_pclk = ~cam_pclk;

    logic [25:0] exp_q [$];
    logic [25:0] exp_w;
    int          errors = 0;
    int          checks = 0;
    int          beats  = 0;
    int          tusers = 0;
    bit          sof_next  = 1'b0;
    bit          chk_stall = 1'b0;
    logic        stall_prev = 1'b0;
    logic [23:0] stall_data = '0;

    // output monitor, sampled on the falling edge
    always @(negedge cam_pclk) begin
        if (chk_stall && stall_prev) begin
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== stall_data) begin
                errors++;
                $display("FAIL stall_hold: tvalid=%b tdata=%h, required tvalid=1 tdata=%h",
                         m_axis_tvalid, m_axis_tdata, stall_data);
            end
        end
        stall_prev = m_axis_tvalid && !m_axis_tready;
        stall_data = m_axis_tdata;
        if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
            beats++;
            if (m_axis_tuser === 1'b1) tusers++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got user=%b last=%b data=%h, required no beat",
                         m_axis_tuser, m_axis_tlast, m_axis_tdata);
            end else begin
                exp_w = exp_q.pop_front();
                if ({m_axis_tuser, m_axis_tlast, m_axis_tdata} !== exp_w) begin
                    errors++;
                    $display("FAIL beat%0d: got user=%b last=%b data=%h, required user=%b last=%b data=%h",
                             beats - 1, m_axis_tuser, m_axis_tlast, m_axis_tdata,
                             exp_w[25], exp_w[24], exp_w[23:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge cam_pclk);
        #1;
    endtask

    task automatic idle_in();
        in_vsync = 1'b0; in_href = 1'b0; in_de = 1'b0; in_ce = 1'b0;
    endtask

    task automatic send_vsync();
        cyc(); idle_in(); in_vsync = 1'b1;
        cyc(); in_vsync = 1'b0;
        repeat (4) cyc();
        sof_next = 1'b1;
    endtask

    // n pixels; only the first n_exp are expected downstream; gap inserts ce=0 cycles
    task automatic send_line(input int n, input int n_exp, input bit gap);
        logic [23:0] d;
        for (int i = 0; i < n; i++) begin
            if (gap && (i % 2 == 1)) begin
                cyc(); in_href = 1'b1; in_de = 1'b1; in_ce = 1'b0; in_data = 24'($urandom);
            end
            cyc();
            d = 24'($urandom);
            in_href = 1'b1; in_de = 1'b1; in_ce = 1'b1; in_data = d;
            if (i < n_exp) begin
                exp_q.push_back({sof_next, (i == n - 1), d});
                sof_next = 1'b0;
            end
        end
        cyc(); idle_in();
        cyc();
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid !== 1'b0) && t < 500) begin
            @(negedge cam_pclk);
            t++;
        end
        checks++;
        if (t >= 500) begin
            errors++;
            $display("FAIL %s_drain: %0d beats still expected, tvalid=%b, required all drained",
                     name, exp_q.size(), m_axis_tvalid);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle_in(); in_data = '0; m_axis_tready = 1'b1;
        repeat (3) cyc();
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tuser !== 1'b0 || m_axis_tlast !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: tvalid=%b tuser=%b tlast=%b, required 0 0 0",
                     m_axis_tvalid, m_axis_tuser, m_axis_tlast);
        end
        checks++;
        if (m_axis_tdata !== 24'd0) begin
            errors++;
            $display("FAIL reset_tdata: got %h, required 000000", m_axis_tdata);
        end
        checks++;
        if (ovf_sticky !== 1'b0 || drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_ovf: ovf=%b drop_cnt=%0d, required 0 0", ovf_sticky, drop_cnt);
        end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_pre_sof();
        int b0 = beats;
        send_line(8, 0, 1'b0);
        repeat (6) cyc();
        checks++;
        if (beats != b0 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL pre_sof_output: beats=%0d tvalid=%b, required 0 beats tvalid=0",
                     beats - b0, m_axis_tvalid);
        end
        checks++;
        if (drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL pre_sof_drop: drop_cnt=%0d, required 0", drop_cnt);
        end
    endtask

    task automatic test_frames();
        int b0 = beats;
        int u0 = tusers;
        for (int f = 0; f < 2; f++) begin
            send_vsync();
            for (int l = 0; l < 4; l++) send_line(8, 8, f == 1);
        end
        send_vsync();
        wait_drain("frames");
        checks++;
        if (beats - b0 != 64 || tusers - u0 != 2) begin
            errors++;
            $display("FAIL frames_count: beats=%0d tusers=%0d, required 64 2", beats - b0, tusers - u0);
        end
`ifdef CMOS_AXIS_STATS_EN
        checks++;
        if (line_len !== 12'd8 || frame_lines !== 12'd4) begin
            errors++;
            $display("FAIL stats: line_len=%0d frame_lines=%0d, required 8 4", line_len, frame_lines);
        end
`endif
    endtask

    task automatic test_backpressure();
        int b0 = beats;
        chk_stall = 1'b1;
        send_vsync();
        fork
            send_line(8, 8, 1'b0);
            begin
                repeat (30) begin
                    cyc();
                    m_axis_tready = ~m_axis_tready;
                end
            end
        join
        cyc();
        m_axis_tready = 1'b1;
        chk_stall = 1'b0;
        wait_drain("backpressure");
        checks++;
        if (beats - b0 != 8) begin
            errors++;
            $display("FAIL backpressure_count: beats=%0d, required 8", beats - b0);
        end
    endtask

    task automatic test_href_stuck();
        int b0 = beats;
        logic [23:0] d;
        send_vsync();
        for (int i = 0; i < 5; i++) begin
            cyc();
            d = 24'($urandom);
            in_href = 1'b1; in_de = 1'b1; in_ce = 1'b1; in_data = d;
            exp_q.push_back({sof_next, (i == 4), d});
            sof_next = 1'b0;
        end
        cyc(); in_de = 1'b0; in_ce = 1'b0;
        cyc(); in_vsync = 1'b1;
        cyc(); in_vsync = 1'b0;
        repeat (4) cyc();
        sof_next = 1'b1;
        send_line(4, 4, 1'b0);
        wait_drain("href_stuck");
        checks++;
        if (beats - b0 != 9) begin
            errors++;
            $display("FAIL href_stuck_count: beats=%0d, required 9", beats - b0);
        end
    endtask

    task automatic test_overflow();
        int b0 = beats;
        m_axis_tready = 1'b0;
        send_vsync();
        send_line(20, 16, 1'b0);
        send_line(20, 0, 1'b0);
        repeat (4) cyc();
        checks++;
        if (beats != b0 || m_axis_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL overflow_hold: beats=%0d tvalid=%b, required 0 1", beats - b0, m_axis_tvalid);
        end
        checks++;
        if (ovf_sticky !== 1'b1 || drop_cnt !== 16'd1) begin
            errors++;
            $display("FAIL overflow_flags: ovf=%b drop_cnt=%0d, required 1 1", ovf_sticky, drop_cnt);
        end
        m_axis_tready = 1'b1;
        send_vsync();
        send_line(8, 8, 1'b0);
        wait_drain("overflow");
        checks++;
        if (beats - b0 != 24) begin
            errors++;
            $display("FAIL overflow_count: beats=%0d, required 24", beats - b0);
        end
    endtask

    task automatic test_reset_mid();
        int b0;
        m_axis_tready = 1'b0;
        send_vsync();
        sof_next = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            in_href = 1'b1; in_de = 1'b1; in_ce = 1'b1; in_data = 24'($urandom);
        end
        cyc();
        checks++;
        if (m_axis_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: tvalid=%b, required 1", m_axis_tvalid);
        end
        rst_n = 1'b0;
        cyc();
        checks++;
        if (m_axis_tvalid !== 1'b0 || ovf_sticky !== 1'b0 || drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid: tvalid=%b ovf=%b drop_cnt=%0d, required 0 0 0",
                     m_axis_tvalid, ovf_sticky, drop_cnt);
        end
`ifdef CMOS_AXIS_STATS_EN
        checks++;
        if (line_len !== 12'd0 || frame_lines !== 12'd0) begin
            errors++;
            $display("FAIL reset_mid_stats: line_len=%0d frame_lines=%0d, required 0 0",
                     line_len, frame_lines);
        end
`endif
        exp_q.delete();
        idle_in();
        rst_n = 1'b1;
        m_axis_tready = 1'b1;
        cyc();
        b0 = beats;
        send_line(8, 0, 1'b0);
        repeat (6) cyc();
        checks++;
        if (beats != b0 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_wait_sof: beats=%0d tvalid=%b, required 0 0", beats - b0, m_axis_tvalid);
        end
    endtask

    initial begin
        test_reset();
        test_pre_sof();
        test_frames();
        test_backpressure();
        test_href_stuck();
        test_overflow();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
